sd_cmd_line_ctrl: RTL and testbench
===================================

Name: sd_cmd_line_ctrl

Overview:
- Command-line sequencer for the SD host physical layer.
- Accepts a pre-built command frame from the upper layer and drives the parallel_serial converter to shift it out.
- Owns the CMD pad direction: drives it during transmit, turns it around, then waits for and deserializes the card response.
- Reports response capture or no-response timeout. Sits between the command builder and the parallel_serial/pad pair.

Parameters:
FRAME_WIDTH, 38, command frame width in bits (fits the 6-bit oTx_framesize)
RESP_WIDTH, 38, response frame width in bits, start bit included
TURN_CYCLES, 2, SD clock cycles with pad released before response sampling starts
TIMEOUT_CYCLES, 64, max cycles in WAIT_START before declaring no response

Ports:
iSD_clock  input  1  SD clock; all logic on its rising edge
iReset  input  1  asynchronous, active-low reset
iCmd_valid  input  1  upper layer offers a command
iCmd_frame  input  FRAME_WIDTH  command frame, MSB sent first
iResp_expected  input  1  sampled with the command; 1 = a response follows
oCmd_ready  output  1  controller idle, can accept a command
oBusy  output  1  high in every state except IDLE
oTx_enable  output  1  enable to parallel_serial
oTx_load  output  1  one-cycle load strobe to parallel_serial
oTx_parallel  output  FRAME_WIDTH  frame presented to parallel_serial
oTx_framesize  output  6  constant FRAME_WIDTH
iTx_complete  input  1  parallel_serial finished shifting the frame
oPad_output_input  output  1  pad direction: 1 = host drives (write), 0 = host reads
iPad_data  input  1  CMD line value read from the pad
oResp_valid  output  1  one-cycle pulse; oResp_frame is valid
oResp_frame  output  RESP_WIDTH  captured response, start bit at MSB
oTimeout  output  1  one-cycle pulse; no start bit within TIMEOUT_CYCLES

Behaviour:
- Reset (iReset=0, async): state IDLE; all outputs 0, except oCmd_ready=1 and oTx_framesize=FRAME_WIDTH. Captured frame and counters are cleared. Reset asserted mid-transfer aborts immediately: no oResp_valid or oTimeout pulse is issued.
- IDLE:
  - oCmd_ready=1.
  - On iCmd_valid=1: latch iCmd_frame into oTx_parallel and latch iResp_expected; go to LOAD. oCmd_ready falls on the next cycle.
  - iCmd_valid in any other state is ignored.
- LOAD (1 cycle): oTx_enable=1, oTx_load=1, oPad_output_input=1; then SEND.
- SEND:
  - oTx_enable=1, oPad_output_input=1, oTx_load=0.
  - Stay until iTx_complete=1.
  - Then go to TURNAROUND if a response is expected, else to DONE.
  - iTx_complete seen in LOAD is ignored.
- TURNAROUND:
  - oTx_enable=0, oPad_output_input=0.
  - Count exactly TURN_CYCLES cycles, then go to WAIT_START.
  - The pad is not sampled during this state.
- WAIT_START:
  - oPad_output_input=0. Sample iPad_data each cycle.
  - iPad_data=0 (start bit): shift 0 into the response register; bit counter = RESP_WIDTH-1; go to RECEIVE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES with no start bit: pulse oTimeout for 1 cycle, go to IDLE.
  - A start bit seen on the same cycle the timeout counter reaches its limit wins; no timeout is reported.
- RECEIVE:
  - Shift iPad_data in MSB-first each cycle and decrement the bit counter.
  - When the last bit is captured (counter 1→0): on the next cycle oResp_frame is updated and oResp_valid pulses for 1 cycle; go to IDLE.
  - oResp_frame holds its value until the next response is captured. The frame is not updated by a timeout.
- DONE (no-response path): 1 cycle, all strobes 0, then IDLE. No oResp_valid, no oTimeout.
- Latency:
  - From iCmd_valid accepted to oTx_load: 1 cycle.
  - From iTx_complete to the first pad sample: TURN_CYCLES+1 cycles.
  - From the last response bit to oResp_valid: 1 cycle.
- Counters: widths are $clog2 of their maximum +1. There is no wrap-around in normal use; the timeout counter is saturated by the state exit.

Test Plan:
1. Reset, then command with no response: iCmd_frame=38'd33, iResp_expected=0, iTx_complete after 38 cycles -> oTx_load pulses 1 cycle after accept, oTx_parallel=33, oPad_output_input=1 in LOAD/SEND, back to IDLE (oCmd_ready=1) 2 cycles after complete, no oResp_valid/oTimeout.
2. Command with response: pad drives start bit 0 at the 5th WAIT_START cycle, then pattern 37'h15_5555_5555 -> oResp_valid single pulse, oResp_frame={1'b0,37'h15_5555_5555}, oPad_output_input=0 from TURNAROUND on.
3. Timeout: iResp_expected=1, pad held at 1 -> oTimeout pulses exactly TIMEOUT_CYCLES=64 cycles after WAIT_START entry; oResp_frame unchanged; oCmd_ready=1 next cycle.
4. Turnaround guard: pad at 0 during both TURNAROUND cycles, then 1 -> no start bit detected during turnaround; timeout occurs.
5. Reset mid-RECEIVE at bit 20: iReset=0 asynchronously -> all outputs at reset values in the same cycle, no oResp_valid; a new command after release completes normally.
6. Busy rejection: iCmd_valid held high throughout SEND with a different frame -> oTx_parallel stays at the first frame; second command accepted only after return to IDLE.

Source files
------------

// File: rtl/sd_cmd_line_ctrl_if.sv
// Bundles the upper-layer command, parallel_serial and pad signals of the CMD line sequencer.
// The slave modport is the sequencer. The master modport is the surrounding logic:
// command builder, parallel_serial and CMD pad.
interface sd_cmd_line_ctrl_if #(
  parameter int unsigned FRAME_WIDTH = 38,
  parameter int unsigned RESP_WIDTH  = 38
);
  logic                   iCmd_valid;
  logic [FRAME_WIDTH-1:0] iCmd_frame;
  logic                   iResp_expected;
  logic                   oCmd_ready;
  logic                   oBusy;
  logic                   oTx_enable;
  logic                   oTx_load;
  logic [FRAME_WIDTH-1:0] oTx_parallel;
  logic [5:0]             oTx_framesize;
  logic                   iTx_complete;
  logic                   oPad_output_input;
  logic                   iPad_data;
  logic                   oResp_valid;
  logic [RESP_WIDTH-1:0]  oResp_frame;
  logic                   oTimeout;

  modport slave (
    input  iCmd_valid, iCmd_frame, iResp_expected, iTx_complete, iPad_data,
    output oCmd_ready, oBusy, oTx_enable, oTx_load, oTx_parallel, oTx_framesize,
           oPad_output_input, oResp_valid, oResp_frame, oTimeout
  );

  modport master (
    output iCmd_valid, iCmd_frame, iResp_expected, iTx_complete, iPad_data,
    input  oCmd_ready, oBusy, oTx_enable, oTx_load, oTx_parallel, oTx_framesize,
           oPad_output_input, oResp_valid, oResp_frame, oTimeout
  );
endinterface

// File: rtl/sd_cmd_line_ctrl.sv
// SD CMD line sequencer. It loads a command frame into parallel_serial and owns the
// CMD pad direction while the frame is sent. When a response is expected it releases
// the pad, waits for the card's start bit, and deserializes the response. A missing
// start bit ends in a timeout.
// Ports:
//   iSD_clock - SD clock; all logic runs on its rising edge.
//   iReset    - asynchronous reset, active low.
//   bus       - command, parallel_serial and pad signals (sd_cmd_line_ctrl_if.slave).
module sd_cmd_line_ctrl #(
  parameter int unsigned FRAME_WIDTH    = 38,
  parameter int unsigned RESP_WIDTH     = 38,
  parameter int unsigned TURN_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic               iSD_clock,
  input logic               iReset,
  sd_cmd_line_ctrl_if.slave bus
);
  localparam int unsigned TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES + 1) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W  = $clog2(RESP_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, TURNAROUND, WAIT_START, RECEIVE, DONE
  } state_t;

  state_t                 state, stateN;
  logic                   cmdReady, cmdReadyN;
  logic                   busy, busyN;
  logic                   txDrive, txDriveN;   // tx enable and pad direction are identical
  logic                   txLoad, txLoadN;
  logic                   respValid, respValidN;
  logic                   timeout, timeoutN;
  logic                   respExp, respExpN;
  logic [FRAME_WIDTH-1:0] txPar, txParN;
  logic [TURN_W-1:0]      turnCnt, turnCntN;
  logic [TO_W-1:0]        toCnt, toCntN;
  logic [BIT_W-1:0]       bitCnt, bitCntN;
  logic [RESP_WIDTH-1:0]  shiftReg, shiftN;
  logic [RESP_WIDTH-1:0]  respFrame, respFrameN;

  // State register plus registered outputs and datapath.
  always_ff @(posedge iSD_clock or negedge iReset) begin
    if (!iReset) begin
      state     <= IDLE;
      cmdReady  <= 1'b1;
      busy      <= 1'b0;
      txDrive   <= 1'b0;
      txLoad    <= 1'b0;
      respValid <= 1'b0;
      timeout   <= 1'b0;
      respExp   <= 1'b0;
      txPar     <= '0;
      turnCnt   <= '0;
      toCnt     <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      respFrame <= '0;
    end else begin
      state     <= stateN;
      cmdReady  <= cmdReadyN;
      busy      <= busyN;
      txDrive   <= txDriveN;
      txLoad    <= txLoadN;
      respValid <= respValidN;
      timeout   <= timeoutN;
      respExp   <= respExpN;
      txPar     <= txParN;
      turnCnt   <= turnCntN;
      toCnt     <= toCntN;
      bitCnt    <= bitCntN;
      shiftReg  <= shiftN;
      respFrame <= respFrameN;
    end
  end

  // Next state and next register values.
  always_comb begin
    stateN     = state;
    respValidN = 1'b0;
    timeoutN   = 1'b0;
    respExpN   = respExp;
    txParN     = txPar;
    turnCntN   = turnCnt;
    toCntN     = toCnt;
    bitCntN    = bitCnt;
    shiftN     = shiftReg;
    respFrameN = respFrame;

    unique case (state)
      IDLE: begin
        if (bus.iCmd_valid) begin
          txParN   = bus.iCmd_frame;
          respExpN = bus.iResp_expected;
          stateN   = LOAD;
        end
      end
      LOAD: stateN = SEND;   // a completion this early cannot belong to the new frame
      SEND: begin
        if (bus.iTx_complete) begin
          turnCntN = '0;
          stateN   = respExp ? TURNAROUND : DONE;
        end
      end
      TURNAROUND: begin
        if (turnCnt == TURN_W'(TURN_CYCLES - 1)) begin
          toCntN = '0;
          stateN = WAIT_START;
        end else begin
          turnCntN = turnCnt + TURN_W'(1);
        end
      end
      WAIT_START: begin
        // A start bit on the last allowed cycle takes priority over the timeout.
        if (!bus.iPad_data) begin
          shiftN  = {shiftReg[RESP_WIDTH-2:0], 1'b0};
          bitCntN = BIT_W'(RESP_WIDTH - 1);
          stateN  = RECEIVE;
        end else if (toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          toCntN   = toCnt + TO_W'(1);
          timeoutN = 1'b1;
          stateN   = IDLE;
        end else begin
          toCntN = toCnt + TO_W'(1);
        end
      end
      RECEIVE: begin
        shiftN  = {shiftReg[RESP_WIDTH-2:0], bus.iPad_data};
        bitCntN = bitCnt - BIT_W'(1);
        if (bitCnt == BIT_W'(1)) begin
          respFrameN = shiftN;
          respValidN = 1'b1;
          stateN     = IDLE;
        end
      end
      DONE:    stateN = IDLE;
      default: stateN = IDLE;
    endcase

    // Level outputs follow the state being entered, so they are registered with it.
    cmdReadyN = (stateN == IDLE);
    busyN     = (stateN != IDLE);
    txDriveN  = (stateN == LOAD) || (stateN == SEND);
    txLoadN   = (stateN == LOAD);
  end

  assign bus.oCmd_ready        = cmdReady;
  assign bus.oBusy             = busy;
  assign bus.oTx_enable        = txDrive;
  assign bus.oTx_load          = txLoad;
  assign bus.oTx_parallel      = txPar;
  assign bus.oTx_framesize     = 6'(FRAME_WIDTH);
  assign bus.oPad_output_input = txDrive;
  assign bus.oResp_valid       = respValid;
  assign bus.oResp_frame       = respFrame;
  assign bus.oTimeout          = timeout;
endmodule

// File: tb/tb_sd_cmd_line_ctrl.sv
// Bench for sd_cmd_line_ctrl. Stimulus pushes the expected cycle and data of each load
// strobe, response pulse, timeout pulse and oCmd_ready rise into one queue per event kind.
// A negedge monitor pops from the matching queue each time the DUT presents that event.
module tb_sd_cmd_line_ctrl;
  localparam int unsigned FW = 38;
  localparam int unsigned RW = 38;

  typedef struct {
    int unsigned cyc;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        rstN;
  int unsigned cyc;
  int unsigned errors;
  int unsigned checks;
  logic        prevReady = 1'b1;
  logic [RW-1:0] expFrame;

  exp_t loadQ[$];
  exp_t respQ[$];
  exp_t toQ[$];
  exp_t readyQ[$];

  sd_cmd_line_ctrl_if #(.FRAME_WIDTH(FW), .RESP_WIDTH(RW)) bus ();

  sd_cmd_line_ctrl #(
    .FRAME_WIDTH(FW), .RESP_WIDTH(RW), .TURN_CYCLES(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .iSD_clock(clk),
    .iReset(rstN),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every strobe the DUT presents must match the next expected entry of its kind.
  always @(negedge clk) begin
    exp_t e;
    if (bus.oTx_load) begin
      if (loadQ.size() == 0) chk("load_unexpected", 64'(1), 64'(0));
      else begin
        e = loadQ.pop_front();
        chk("load_cycle", 64'(cyc), 64'(e.cyc));
        chk("load_frame", 64'(bus.oTx_parallel), e.data);
        chk("load_pad_dir", 64'(bus.oPad_output_input), 64'(1));
      end
    end
    if (bus.oResp_valid) begin
      if (respQ.size() == 0) chk("resp_unexpected", 64'(1), 64'(0));
      else begin
        e = respQ.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        chk("resp_frame", 64'(bus.oResp_frame), e.data);
      end
    end
    if (bus.oTimeout) begin
      if (toQ.size() == 0) chk("timeout_unexpected", 64'(1), 64'(0));
      else begin
        e = toQ.pop_front();
        chk("timeout_cycle", 64'(cyc), 64'(e.cyc));
        chk("timeout_frame_kept", 64'(bus.oResp_frame), e.data);
      end
    end
    if (bus.oCmd_ready && !prevReady) begin
      if (readyQ.size() == 0) chk("ready_unexpected", 64'(1), 64'(0));
      else begin
        e = readyQ.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prevReady = bus.oCmd_ready;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, "_ready"},     64'(bus.oCmd_ready), 64'(1));
    chk({tag, "_busy"},      64'(bus.oBusy), 64'(0));
    chk({tag, "_txen"},      64'(bus.oTx_enable), 64'(0));
    chk({tag, "_txload"},    64'(bus.oTx_load), 64'(0));
    chk({tag, "_paddir"},    64'(bus.oPad_output_input), 64'(0));
    chk({tag, "_respvalid"}, 64'(bus.oResp_valid), 64'(0));
    chk({tag, "_timeout"},   64'(bus.oTimeout), 64'(0));
    chk({tag, "_framesize"}, 64'(bus.oTx_framesize), 64'(38));
    chk({tag, "_parallel"},  64'(bus.oTx_parallel), 64'(0));
    chk({tag, "_respframe"}, 64'(bus.oResp_frame), 64'(0));
  endtask

  // Offer a command while idle; it is accepted on the next edge.
  task automatic issue(input logic [FW-1:0] f, input logic re);
    bus.iCmd_valid     = 1'b1;
    bus.iCmd_frame     = f;
    bus.iResp_expected = re;
    loadQ.push_back('{cyc + 1, 64'(f)});
    tick(1);
    bus.iCmd_valid     = 1'b0;
    bus.iCmd_frame     = '0;
    bus.iResp_expected = 1'b0;
  endtask

  // Shift phase: iTx_complete 38 cycles after accept; returns the cycle it was raised.
  task automatic finishSend(input logic re, input logic [FW-1:0] f, output int unsigned c);
    tick(10);
    chk("send_paddir", 64'(bus.oPad_output_input), 64'(1));
    chk("send_txen",   64'(bus.oTx_enable), 64'(1));
    chk("send_txload", 64'(bus.oTx_load), 64'(0));
    chk("send_busy",   64'(bus.oBusy), 64'(1));
    chk("send_ready",  64'(bus.oCmd_ready), 64'(0));
    chk("send_frame",  64'(bus.oTx_parallel), 64'(f));
    tick(27);
    bus.iTx_complete = 1'b1;
    c = cyc;
    tick(1);
    bus.iTx_complete = 1'b0;
    chk("post_send_paddir", 64'(bus.oPad_output_input), 64'(0));
    chk("post_send_txen",   64'(bus.oTx_enable), 64'(0));
    chk("post_send_busy",   64'(bus.oBusy), 64'(1));
    if (!re) readyQ.push_back('{c + 2, 64'(0)});
  endtask

  initial begin
    int unsigned c;
    logic [36:0] pat;
    logic [FW-1:0] frameA;
    logic [FW-1:0] frameB;
    errors = 0;
    checks = 0;
    pat    = 37'h15_5555_5555;
    frameA = 38'h2A_1234_5678;
    frameB = 38'h15_8765_4321;
    rstN = 1'b1;
    bus.iCmd_valid     = 1'b0;
    bus.iCmd_frame     = '0;
    bus.iResp_expected = 1'b0;
    bus.iTx_complete   = 1'b0;
    bus.iPad_data      = 1'b1;
    #1 rstN = 1'b0;
    tick(3);
    checkResetValues("reset");
    rstN = 1'b1;
    tick(2);

    // 1: command without response
    issue(38'd33, 1'b0);
    finishSend(1'b0, 38'd33, c);
    tick(1);
    chk("t1_ready_back", 64'(bus.oCmd_ready), 64'(1));
    chk("t1_busy_low",   64'(bus.oBusy), 64'(0));
    tick(3);

    // 2: response, start bit on the 5th WAIT_START sample
    issue(frameA, 1'b1);
    finishSend(1'b1, frameA, c);
    tick(4);
    chk("t2_wait_paddir", 64'(bus.oPad_output_input), 64'(0));
    tick(2);
    bus.iPad_data = 1'b0;
    expFrame = {1'b0, pat};
    respQ.push_back('{c + 45, 64'(expFrame)});
    readyQ.push_back('{c + 45, 64'(0)});
    for (int i = 36; i >= 0; i--) begin
      tick(1);
      bus.iPad_data = pat[i];
    end
    tick(1);
    bus.iPad_data = 1'b1;
    tick(3);
    chk("t2_frame_held", 64'(bus.oResp_frame), 64'(expFrame));

    // 3: no response, pad idle high
    issue(frameB, 1'b1);
    finishSend(1'b1, frameB, c);
    toQ.push_back('{c + 67, 64'(expFrame)});
    readyQ.push_back('{c + 67, 64'(0)});
    tick(67);
    chk("t3_ready_after", 64'(bus.oCmd_ready), 64'(1));
    chk("t3_frame_kept",  64'(bus.oResp_frame), 64'(expFrame));
    tick(2);

    // 4: pad low only during turnaround must not count as a start bit
    issue(38'd7, 1'b1);
    finishSend(1'b1, 38'd7, c);
    bus.iPad_data = 1'b0;
    tick(2);
    bus.iPad_data = 1'b1;
    toQ.push_back('{c + 67, 64'(expFrame)});
    readyQ.push_back('{c + 67, 64'(0)});
    tick(67);

    // 5: reset in the middle of a response
    issue(38'd99, 1'b1);
    finishSend(1'b1, 38'd99, c);
    tick(6);
    bus.iPad_data = 1'b0;
    for (int i = 36; i >= 17; i--) begin
      tick(1);
      bus.iPad_data = pat[i];
    end
    chk("t5_rx_busy",   64'(bus.oBusy), 64'(1));
    chk("t5_rx_paddir", 64'(bus.oPad_output_input), 64'(0));
    #2 rstN = 1'b0;
    readyQ.push_back('{cyc, 64'(0)});
    #1;
    checkResetValues("midrx_reset");
    bus.iPad_data = 1'b1;
    tick(2);
    rstN = 1'b1;
    tick(2);
    issue(38'h3F_0F0F_0F0F, 1'b0);
    finishSend(1'b0, 38'h3F_0F0F_0F0F, c);
    tick(3);

    // 6: second command held during SEND is ignored until IDLE
    bus.iCmd_valid     = 1'b1;
    bus.iCmd_frame     = frameA;
    bus.iResp_expected = 1'b0;
    loadQ.push_back('{cyc + 1, 64'(frameA)});
    tick(1);
    bus.iCmd_frame = frameB;
    tick(20);
    chk("t6_send_frame", 64'(bus.oTx_parallel), 64'(frameA));
    tick(17);
    bus.iTx_complete = 1'b1;
    c = cyc;
    tick(1);
    bus.iTx_complete = 1'b0;
    chk("t6_done_frame", 64'(bus.oTx_parallel), 64'(frameA));
    readyQ.push_back('{c + 2, 64'(0)});
    loadQ.push_back('{c + 3, 64'(frameB)});
    tick(2);
    bus.iCmd_valid = 1'b0;
    bus.iCmd_frame = '0;
    chk("t6_second_frame", 64'(bus.oTx_parallel), 64'(frameB));
    tick(37);
    bus.iTx_complete = 1'b1;
    c = cyc;
    tick(1);
    bus.iTx_complete = 1'b0;
    readyQ.push_back('{c + 2, 64'(0)});
    tick(5);

    chk("left_load",    64'(loadQ.size()), 64'(0));
    chk("left_resp",    64'(respQ.size()), 64'(0));
    chk("left_timeout", 64'(toQ.size()), 64'(0));
    chk("left_ready",   64'(readyQ.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
